hazard_ctrl_nway: RTL

//  N-lane generalisation of the superscalar hazard unit. Sits beside the IF/ID/EXE/MEM/WB latches and drives their stall/flush enables.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_ctrl_nway_if.sv | 60 ++++++
 rtl/hazard_reg_match.sv | 18 +
 rtl/hazard_ctrl_nway.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the N-lane hazard unit.
// FSM state enum, r0 specifier value, lane-slice offset helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    RELEASE
  } hz_state_e;

  localparam int REG_ZERO = 0;

  // LSB of lane k in a bus packed as NLANES fields of width w.
  function automatic int lane_lsb(
    input int k,
    input int w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_nway_if.sv
// hazard_ctrl_nway_if: pipeline <-> hazard unit bundle.
// master = pipeline side (drives ID/EXE/MEM info, mem_busy),
// slave = hazard unit (drives stall/flush, mem_timeout, perf_*).
interface hazard_ctrl_nway_if #(
  parameter int NLANES = 2,
  parameter int REGW   = 5
);

  logic [NLANES-1:0]      jump_id;
  logic [NLANES-1:0]      branch_id;
  logic [NLANES-1:0]      takebranch_id;
  logic [NLANES*REGW-1:0] rs_id;
  logic [NLANES*REGW-1:0] rt_id;
  logic [NLANES-1:0]      regwrite_exe;
  logic [NLANES-1:0]      memtoreg_exe;
  logic [NLANES*REGW-1:0] rt_exe;
  logic [NLANES*REGW-1:0] writereg_exe;
  logic [NLANES-1:0]      memtoreg_mem;
  logic [NLANES*REGW-1:0] writereg_mem;
  logic                   mem_busy;

  logic [NLANES-1:0]      stall_if;
  logic [NLANES-1:0]      stall_id;
  logic [NLANES-1:0]      stall_exe;
  logic [NLANES-1:0]      stall_mem;
  logic [NLANES-1:0]      flush_id;
  logic [NLANES-1:0]      flush_exe;
  logic [NLANES-1:0]      flush_wb;
  logic                   mem_timeout;
  logic [31:0]            perf_lu_cnt;
  logic [31:0]            perf_br_cnt;
  logic [31:0]            perf_mem_cnt;

  modport master (
    output jump_id, branch_id, takebranch_id,
    output rs_id, rt_id,
    output regwrite_exe, memtoreg_exe,
    output rt_exe, writereg_exe,
    output memtoreg_mem, writereg_mem,
    output mem_busy,
    input  stall_if, stall_id, stall_exe, stall_mem,
    input  flush_id, flush_exe, flush_wb,
    input  mem_timeout,
    input  perf_lu_cnt, perf_br_cnt, perf_mem_cnt
  );

  modport slave (
    input  jump_id, branch_id, takebranch_id,
    input  rs_id, rt_id,
    input  regwrite_exe, memtoreg_exe,
    input  rt_exe, writereg_exe,
    input  memtoreg_mem, writereg_mem,
    input  mem_busy,
    output stall_if, stall_id, stall_exe, stall_mem,
    output flush_id, flush_exe, flush_wb,
    output mem_timeout,
    output perf_lu_cnt, perf_br_cnt, perf_mem_cnt
  );

endinterface

// File: rtl/hazard_reg_match.sv
// hazard_reg_match: one specifier comparator with r0 exclusion.
// src_i/dst_i specifiers, en_i qualifier, hit_o match.
module hazard_reg_match
  import hazard_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src_i,
  input  logic [REGW-1:0] dst_i,
  input  logic            en_i,
  output logic            hit_o
);

  assign hit_o = en_i
              && (src_i == dst_i)
              && (dst_i != REGW'(REG_ZERO));

endmodule

// File: rtl/hazard_ctrl_nway.sv
// hazard_ctrl_nway: N-lane stall/flush controller.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   ID/EXE/MEM specifiers and enables, mem_busy in;
//   stall_*/flush_* (lockstep per lane), mem_timeout, perf_* out.
// HAZ_PERF_CNT_EN: enables the three 32-bit stall counters;
//   otherwise perf_* are tied to 0.
module hazard_ctrl_nway
  import hazard_pkg::*;
#(
  parameter int NLANES  = 2,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_nway_if.slave bus
);

  localparam int NP  = NLANES * NLANES;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  logic busy;
  assign busy = bus.mem_busy;

  // pair index p = producer*NLANES + consumer
  logic [NP-1:0] lu_rs, lu_rt;
  logic [NP-1:0] bx_rs, bx_rt;
  logic [NP-1:0] bm_rs, bm_rt;

  for (genvar i = 0; i < NLANES; i++) begin : g_prod
    for (genvar j = 0; j < NLANES; j++) begin : g_cons
      localparam int P  = i * NLANES + j;
      localparam int LI = lane_lsb(i, REGW);
      localparam int LJ = lane_lsb(j, REGW);

      hazard_reg_match #(.REGW(REGW)) u_lu_rs (
        .src_i (bus.rs_id[LJ +: REGW]),
        .dst_i (bus.rt_exe[LI +: REGW]),
        .en_i  (bus.memtoreg_exe[i]),
        .hit_o (lu_rs[P])
      );
      hazard_reg_match #(.REGW(REGW)) u_lu_rt (
        .src_i (bus.rt_id[LJ +: REGW]),
        .dst_i (bus.rt_exe[LI +: REGW]),
        .en_i  (bus.memtoreg_exe[i]),
        .hit_o (lu_rt[P])
      );
      hazard_reg_match #(.REGW(REGW)) u_bx_rs (
        .src_i (bus.rs_id[LJ +: REGW]),
        .dst_i (bus.writereg_exe[LI +: REGW]),
        .en_i  (bus.regwrite_exe[i] & bus.branch_id[j]),
        .hit_o (bx_rs[P])
      );
      hazard_reg_match #(.REGW(REGW)) u_bx_rt (
        .src_i (bus.rt_id[LJ +: REGW]),
        .dst_i (bus.writereg_exe[LI +: REGW]),
        .en_i  (bus.regwrite_exe[i] & bus.branch_id[j]),
        .hit_o (bx_rt[P])
      );
      hazard_reg_match #(.REGW(REGW)) u_bm_rs (
        .src_i (bus.rs_id[LJ +: REGW]),
        .dst_i (bus.writereg_mem[LI +: REGW]),
        .en_i  (bus.memtoreg_mem[i] & bus.branch_id[j]),
        .hit_o (bm_rs[P])
      );
      hazard_reg_match #(.REGW(REGW)) u_bm_rt (
        .src_i (bus.rt_id[LJ +: REGW]),
        .dst_i (bus.writereg_mem[LI +: REGW]),
        .en_i  (bus.memtoreg_mem[i] & bus.branch_id[j]),
        .hit_o (bm_rt[P])
      );
    end
  end

  logic lu_haz, br_haz, redirect;
  assign lu_haz   = |{lu_rs, lu_rt};
  assign br_haz   = |{bx_rs, bx_rt, bm_rs, bm_rt};
  assign redirect = |(bus.jump_id
                   | (bus.branch_id & bus.takebranch_id));

  hz_state_e      state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           to_q, to_d;
  logic           pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wd_q    <= '0;
      to_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (busy) state_d = MEM_WAIT;
      MEM_WAIT: if (!busy) state_d = RELEASE;
      RELEASE:  state_d = busy ? MEM_WAIT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // watchdog only runs inside MEM_WAIT; timeout is sticky
  always_comb begin
    wd_d = '0;
    if (state_q == MEM_WAIT) begin
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);
    end
    to_d = to_q
        | ((state_q == MEM_WAIT) && (wd_d == WD_MAX));
  end

  logic s_front, s_back;
  logic f_id, f_exe, f_wb;

  // priority chain: overlapping conditions, so if/else
  always_comb begin
    s_front = 1'b0;
    s_back  = 1'b0;
    f_id    = 1'b0;
    f_exe   = 1'b0;
    f_wb    = 1'b0;
    if (!reset) begin
      if (busy) begin
        s_front = 1'b1;
        s_back  = 1'b1;
        f_wb    = 1'b1;
      end else if (lu_haz || br_haz) begin
        s_front = 1'b1;
        f_exe   = 1'b1;
      end else if (redirect || pend_q) begin
        f_id    = 1'b1;
      end
    end
  end

  // a redirect seen under busy is replayed once busy drops
  always_comb begin
    pend_d = pend_q;
    if (busy && redirect) pend_d = 1'b1;
    else if (f_id)        pend_d = 1'b0;
  end

  assign bus.stall_if    = {NLANES{s_front}};
  assign bus.stall_id    = {NLANES{s_front}};
  assign bus.stall_exe   = {NLANES{s_back}};
  assign bus.stall_mem   = {NLANES{s_back}};
  assign bus.flush_id    = {NLANES{f_id}};
  assign bus.flush_exe   = {NLANES{f_exe}};
  assign bus.flush_wb    = {NLANES{f_wb}};
  assign bus.mem_timeout = to_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] plu_q, pbr_q, pmem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      plu_q  <= '0;
      pbr_q  <= '0;
      pmem_q <= '0;
    end else begin
      if (!busy && lu_haz && plu_q != '1)
        plu_q <= plu_q + 32'd1;
      if (!busy && br_haz && pbr_q != '1)
        pbr_q <= pbr_q + 32'd1;
      if (busy && pmem_q != '1)
        pmem_q <= pmem_q + 32'd1;
    end
  end

  assign bus.perf_lu_cnt  = plu_q;
  assign bus.perf_br_cnt  = pbr_q;
  assign bus.perf_mem_cnt = pmem_q;
`else
  assign bus.perf_lu_cnt  = '0;
  assign bus.perf_br_cnt  = '0;
  assign bus.perf_mem_cnt = '0;
`endif

endmodule
